clkdiv_multi: RTL and testbench



---
 rtl/clkdiv_pkg.sv | 18 +
 rtl/clkdiv_chan.sv | 94 +++++++++
 rtl/clkdiv_multi.sv | 50 +++++
 tb/tb_clkdiv_multi.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clkdiv_pkg.sv
// rtl/clkdiv_pkg.sv - shared constants and helpers for the multi-channel clock divider
//
// Purpose : default widths/ratios and the high-phase length helper used by
//           every divider channel.
// Contents: DIV_W_DEF        default ratio/counter width
//           DEFAULT_DIV_100M ratio giving 1 s from the 100 MHz system clock
//           half_hi(n)       number of high cycles for ratio n, (n+1)>>1
package clkdiv_pkg;

    localparam int DIV_W_DEF        = 32;
    localparam int DEFAULT_DIV_100M = 100000000;

    // Evaluated in 64 bits so (n+1) cannot wrap for any ratio width up to 63.
    function automatic logic [63:0] half_hi(input logic [63:0] n);
        return (n + 64'd1) >> 1;
    endfunction

endpackage

// File: rtl/clkdiv_chan.sv
// rtl/clkdiv_chan.sv - one programmable divider channel with glitch-free ratio reload
//
// Purpose : divides clk_100MHz by a runtime ratio, producing a square wave and
//           a one-cycle tick in the last cycle of each period. New ratios are
//           staged in a pending register and only become active at a period
//           boundary (or immediately while the channel is stopped).
// Ports   : clk_100MHz   system clock, rising edge
//           rst_n        asynchronous active-low reset
//           en           run enable, level
//           div_load     one-cycle strobe, captures div_value as pending ratio
//           div_value    ratio bus, sampled with div_load
//           sync_clr     one-cycle strobe, restarts a running channel at phase 0
//           clk_out      divided square wave, registered
//           tick         last-cycle-of-period pulse, registered
//           div_pending  high while a loaded ratio is not yet active
module clkdiv_chan
    import clkdiv_pkg::*;
#(
    parameter int               DIV_W       = DIV_W_DEF,
    parameter logic [DIV_W-1:0] DEFAULT_DIV = DIV_W'(DEFAULT_DIV_100M)
) (
    input  logic             clk_100MHz,
    input  logic             rst_n,
    input  logic             en,
    input  logic             div_load,
    input  logic [DIV_W-1:0] div_value,
    input  logic             sync_clr,
    output logic             clk_out,
    output logic             tick,
    output logic             div_pending
);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] active;
    logic [DIV_W-1:0] pending;
    logic             was_stopped;

    logic             stopped;
    logic             restart;
    logic [DIV_W-1:0] nxt;
    logic [DIV_W-1:0] n_eff;
    logic [DIV_W-1:0] half;

    // A zero ratio parks the channel exactly like en=0.
    // Any restart (period end, re-entry from stopped, sync_clr) is also the
    // point where the pending ratio is promoted, so the outputs for the new
    // period are already computed against the new ratio.
    always_comb begin
        stopped = !en || (active == '0);
        restart = sync_clr || was_stopped || (cnt == active - DIV_W'(1));
        nxt     = restart ? '0 : cnt + DIV_W'(1);
        n_eff   = restart ? pending : active;
        half    = DIV_W'(half_hi(64'(n_eff)));
    end

    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            active      <= DEFAULT_DIV;
            pending     <= DEFAULT_DIV;
            clk_out     <= 1'b0;
            tick        <= 1'b0;
            div_pending <= 1'b0;
            was_stopped <= 1'b1;
        end else begin
            if (div_load) begin
                pending <= div_value;
            end
            if (stopped) begin
                cnt         <= '0;
                clk_out     <= 1'b0;
                tick        <= 1'b0;
                active      <= pending;
                was_stopped <= 1'b1;
                div_pending <= div_load;
            end else begin
                cnt         <= nxt;
                clk_out     <= (nxt < half);
                tick        <= (nxt == n_eff - DIV_W'(1));
                was_stopped <= 1'b0;
                if (restart) begin
                    active <= pending;
                end
                // A load on the promoting edge is kept for the following wrap.
                if (div_load) begin
                    div_pending <= 1'b1;
                end else if (restart) begin
                    div_pending <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/clkdiv_multi.sv
// rtl/clkdiv_multi.sv - multi-channel runtime-programmable clock divider
//
// Purpose : CHANNELS independent dividers of clk_100MHz sharing one ratio bus
//           and one phase re-alignment strobe (display scan, door timer,
//           1 s and blink timebases).
// Ports   : clk_100MHz   system clock, rising edge
//           rst_n        asynchronous active-low reset
//           en           per-channel run enable
//           div_load     per-channel load strobe for div_value
//           div_value    shared ratio bus
//           sync_clr     restarts all running channels at phase 0
//           clk_out      per-channel divided square wave
//           tick         per-channel end-of-period pulse
//           div_pending  per-channel loaded-but-not-active flag
module clkdiv_multi
    import clkdiv_pkg::*;
#(
    parameter int          CHANNELS    = 4,
    parameter int          DIV_W       = DIV_W_DEF,
    parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_100M
) (
    input  logic                clk_100MHz,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] en,
    input  logic [CHANNELS-1:0] div_load,
    input  logic [DIV_W-1:0]    div_value,
    input  logic                sync_clr,
    output logic [CHANNELS-1:0] clk_out,
    output logic [CHANNELS-1:0] tick,
    output logic [CHANNELS-1:0] div_pending
);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        clkdiv_chan #(
            .DIV_W       (DIV_W),
            .DEFAULT_DIV (DIV_W'(DEFAULT_DIV))
        ) u_chan (
            .clk_100MHz  (clk_100MHz),
            .rst_n       (rst_n),
            .en          (en[i]),
            .div_load    (div_load[i]),
            .div_value   (div_value),
            .sync_clr    (sync_clr),
            .clk_out     (clk_out[i]),
            .tick        (tick[i]),
            .div_pending (div_pending[i])
        );
    end

endmodule

// File: tb/tb_clkdiv_multi.sv
// tb/tb_clkdiv_multi.sv - self-checking bench for clkdiv_multi
module tb_clkdiv_multi;

    localparam int CH  = 4;
    localparam int DW  = 32;
    localparam int DEF = 50;

    logic          clk_100MHz = 1'b0;
    logic          rst_n;
    logic [CH-1:0] en;
    logic [CH-1:0] div_load;
    logic [DW-1:0] div_value;
    logic          sync_clr;
    logic [CH-1:0] clk_out;
    logic [CH-1:0] tick;
    logic [CH-1:0] div_pending;

    initial forever #5 clk_100MHz = ~clk_100MHz;

    clkdiv_multi #(
        .CHANNELS    (CH),
        .DIV_W       (DW),
        .DEFAULT_DIV (DEF)
    ) dut (
        .clk_100MHz  (clk_100MHz),
        .rst_n       (rst_n),
        .en          (en),
        .div_load    (div_load),
        .div_value   (div_value),
        .sync_clr    (sync_clr),
        .clk_out     (clk_out),
        .tick        (tick),
        .div_pending (div_pending)
    );

    typedef struct packed {
        logic [CH-1:0] c;
        logic [CH-1:0] t;
        logic [CH-1:0] p;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    logic [DW-1:0] m_cnt  [CH];
    logic [DW-1:0] m_n    [CH];
    logic [DW-1:0] m_pend [CH];
    logic [CH-1:0] m_clk, m_tick, m_dp, m_idle;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < CH; i++) begin
            m_cnt[i]  = '0;
            m_n[i]    = DW'(DEF);
            m_pend[i] = DW'(DEF);
        end
        m_clk  = '0;
        m_tick = '0;
        m_dp   = '0;
        m_idle = '1;
    endtask

    // Reference behaviour for one rising edge, from the inputs held over it.
    task automatic model_step();
        logic [DW:0]   h;
        logic [DW-1:0] nx;
        for (int i = 0; i < CH; i++) begin
            if (!en[i] || m_n[i] == '0) begin
                m_n[i]    = m_pend[i];
                m_cnt[i]  = '0;
                m_clk[i]  = 1'b0;
                m_tick[i] = 1'b0;
                m_idle[i] = 1'b1;
                m_dp[i]   = 1'b0;
            end else begin
                if (sync_clr || m_idle[i] || m_cnt[i] == m_n[i] - DW'(1)) begin
                    nx      = '0;
                    m_n[i]  = m_pend[i];
                    m_dp[i] = 1'b0;
                end else begin
                    nx = m_cnt[i] + DW'(1);
                end
                h         = ({1'b0, m_n[i]} + (DW+1)'(1)) >> 1;
                m_cnt[i]  = nx;
                m_clk[i]  = ({1'b0, nx} < h);
                m_tick[i] = (nx == m_n[i] - DW'(1));
                m_idle[i] = 1'b0;
            end
            if (div_load[i]) begin
                m_pend[i] = div_value;
                m_dp[i]   = 1'b1;
            end
        end
        sb_q.push_back('{m_clk, m_tick, m_dp});
    endtask

    task automatic cyc();
        @(posedge clk_100MHz);
        model_step();
        #1;
    endtask

    task automatic load(input logic [CH-1:0] m, input logic [DW-1:0] v);
        div_load  = m;
        div_value = v;
        cyc();
        div_load  = '0;
    endtask

    // Scoreboard: compare every edge's expected outputs half a cycle later.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_100MHz);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("sb_clk_out", clk_out, e.c);
                check("sb_tick", tick, e.t);
                check("sb_div_pending", div_pending, e.p);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        int n, first;
        rst_n = 1'b0; en = '0; div_load = '0; div_value = '0; sync_clr = 1'b0;
        model_reset();
        repeat (3) @(posedge clk_100MHz);
        #1;
        check("rst_clk_out", clk_out, 0);
        check("rst_tick", tick, 0);
        check("rst_div_pending", div_pending, 0);
        rst_n = 1'b1;

        // ch0 ratio 5
        load(4'b0001, 5);
        check("ch0_pend_set", div_pending[0], 1);
        cyc();
        check("ch0_pend_clr", div_pending[0], 0);
        en[0] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            cyc();
            check("ch0_clk", clk_out[0], (k % 5) < 3);
            check("ch0_tick", tick[0], (k % 5) == 4);
        end

        // ch1 ratio 4, then ratio 1
        load(4'b0010, 4);
        cyc();
        en[1] = 1'b1;
        for (int k = 0; k < 12; k++) begin
            cyc();
            check("ch1_clk", clk_out[1], (k % 4) < 2);
            check("ch1_tick", tick[1], (k % 4) == 3);
        end
        load(4'b0010, 1);
        repeat (8) cyc();
        for (int k = 0; k < 5; k++) begin
            cyc();
            check("ch1_n1_clk", clk_out[1], 1);
            check("ch1_n1_tick", tick[1], 1);
        end

        // ch2 ratio 6, lowered to 3 mid-period
        load(4'b0100, 6);
        cyc();
        en[2] = 1'b1;
        repeat (3) cyc();
        load(4'b0100, 3);
        check("ch2_pend_mid", div_pending[2], 1);
        check("ch2_clk_cnt3", clk_out[2], 0);
        cyc();
        cyc();
        check("ch2_pend_late", div_pending[2], 1);
        check("ch2_tick_old", tick[2], 1);
        cyc();
        check("ch2_pend_wrap", div_pending[2], 0);
        check("ch2_clk_wrap", clk_out[2], 1);
        for (int k = 1; k < 6; k++) begin
            cyc();
            check("ch2_clk_n3", clk_out[2], (k % 3) < 2);
        end
        load(4'b0100, 6);
        check("ch2_wrapload_pend", div_pending[2], 1);
        cyc();
        cyc();
        check("ch2_wrapload_hold", div_pending[2], 1);
        check("ch2_wrapload_tick", tick[2], 1);
        cyc();
        check("ch2_wrapload_apply", div_pending[2], 0);
        for (int k = 1; k < 6; k++) begin
            cyc();
            check("ch2_clk_n6", clk_out[2], k < 3);
        end

        // sync_clr re-aligns ch0 (5) and ch1 (4)
        load(4'b0010, 4);
        repeat (3) cyc();
        sync_clr = 1'b1;
        cyc();
        sync_clr = 1'b0;
        check("sync_clk", clk_out[1:0], 2'b11);
        n = 0;
        first = -1;
        for (int k = 1; k <= 40; k++) begin
            cyc();
            if (tick[0] && tick[1]) begin
                n++;
                if (first < 0) first = k;
            end
        end
        check("sync_first_coincide", first, 19);
        check("sync_coincide_count", n, 2);

        // ch3: ratio 2, load 0 stops it, load 7 restarts it
        load(4'b1000, 2);
        cyc();
        en[3] = 1'b1;
        repeat (3) cyc();
        load(4'b1000, 0);
        repeat (4) cyc();
        check("ch3_zero_clk", clk_out[3], 0);
        check("ch3_zero_tick", tick[3], 0);
        check("ch3_zero_pend", div_pending[3], 0);
        load(4'b1000, 7);
        check("ch3_load7_pend", div_pending[3], 1);
        cyc();
        check("ch3_load7_applied", div_pending[3], 0);
        check("ch3_load7_idle", clk_out[3], 0);
        for (int k = 0; k < 7; k++) begin
            cyc();
            check("ch3_clk_n7", clk_out[3], k < 4);
        end

        // en dropped mid-period
        en[0] = 1'b0;
        cyc();
        check("ch0_off_clk", clk_out[0], 0);
        check("ch0_off_tick", tick[0], 0);

        // random soak against the reference
        for (int k = 0; k < 300; k++) begin
            en        = CH'($urandom) | CH'($urandom);
            div_load  = CH'($urandom) & CH'($urandom) & CH'($urandom);
            div_value = DW'($urandom_range(0, 9));
            sync_clr  = ($urandom_range(0, 15) == 0);
            cyc();
        end
        div_load = '0;
        sync_clr = 1'b0;

        // asynchronous reset mid-period with a load outstanding
        en = '1;
        load('1, 9);
        repeat (2) cyc();
        #2;
        rst_n = 1'b0;
        model_reset();
        sb_q.delete();
        #1;
        check("async_rst_clk", clk_out, 0);
        check("async_rst_tick", tick, 0);
        check("async_rst_pend", div_pending, 0);
        @(posedge clk_100MHz);
        #1;
        rst_n = 1'b1;

        // default ratio after reset: first tick on the DEF-th enabled edge
        n = 0;
        do begin
            cyc();
            n++;
        end while (!tick[0] && n < 4 * DEF);
        check("default_first_tick", n, DEF);
        repeat (3) cyc();

        @(negedge clk_100MHz);
        @(negedge clk_100MHz);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
